// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encodings and a
// counter-width helper, used by the divider and the multiplier.
package arith_pkg;

  typedef logic [1:0] arith_state_t;

  localparam arith_state_t IDLE = 2'd0;
  localparam arith_state_t CALC = 2'd1;
  localparam arith_state_t DONE = 2'd2;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/unsigned_divider_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module udiv_step #(
  parameter int M = 12
) (
  input  logic [M:0]   pr,
  input  logic         dvd_bit,
  input  logic [M-1:0] dvsr,
  output logic [M:0]   pr_nxt,
  output logic         qbit
);

  logic [M:0] t;

  // Trial subtraction; the partial remainder stays below the divisor, so
  // dropping pr[M] loses nothing for a non-zero divisor.
  always_comb begin
    t = {pr[M-1:0], dvd_bit};
    if (t >= {1'b0, dvsr}) begin
      pr_nxt = t - {1'b0, dvsr};
      qbit   = 1'b1;
    end else begin
      pr_nxt = t;
      qbit   = 1'b0;
    end
  end

endmodule

// File: rtl/unsigned_divider.sv
// Sequential restoring unsigned divider: q = x / y, r = x % y, one quotient
// bit per clock, MSB first.
// Optional feature macro: UDIV_ZERO_DETECT_EN (divide-by-zero short cut and
// div_zero flag). Without it div_zero is tied low and y==0 runs the full
// datapath, which naturally yields q = all ones, r = x[M-1:0].
//
// Handshake: start is a request sampled on a rising edge; it is accepted only
// in IDLE or DONE (ignored in CALC, never queued). busy is high while the
// operation runs; done rises with valid q/r and holds until the next accepted
// start or reset.
module unsigned_divider
  import arith_pkg::*;
#(
  parameter int N = 23,
  parameter int M = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] x,
  input  logic [M-1:0] y,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [M-1:0] r,
  output logic         div_zero,
  output logic [1:0]   dbg_state
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  arith_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [M-1:0]  dvsr_q, dvsr_d;
  logic [M:0]    pr_q, pr_d;
  logic [N-1:0]  q_q, q_d;
  logic [M-1:0]  r_q, r_d;
  logic [M:0]    pr_nxt;
  logic          qbit;
  logic          accept;
  logic          zero_skip;

  udiv_step #(.M(M)) u_step (
    .pr      (pr_q),
    .dvd_bit (dvd_q[N-1]),
    .dvsr    (dvsr_q),
    .pr_nxt  (pr_nxt),
    .qbit    (qbit)
  );

  assign accept = start && (state_q != CALC);

`ifdef UDIV_ZERO_DETECT_EN
  logic dz_q, dz_d;
  assign zero_skip = (y == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (accept) state_d = zero_skip ? DONE : CALC;
      CALC:       if (cnt_q == LAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy      = (state_q == CALC);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Datapath next values: operand capture on accept, one step per CALC edge,
  // result capture on the last step.
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvsr_d = dvsr_q;
    pr_d   = pr_q;
    q_d    = q_q;
    r_d    = r_q;
`ifdef UDIV_ZERO_DETECT_EN
    dz_d   = dz_q;
`endif
    if (accept) begin
      cnt_d  = '0;
      dvd_d  = x;
      dvsr_d = y;
      pr_d   = '0;
`ifdef UDIV_ZERO_DETECT_EN
      dz_d   = 1'b0;
      if (zero_skip) begin
        q_d  = '1;
        r_d  = x[M-1:0];
        dz_d = 1'b1;
      end
`endif
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 1'b1;
      dvd_d = {dvd_q[N-2:0], qbit};
      pr_d  = pr_nxt;
      if (cnt_q == LAST) begin
        q_d = {dvd_q[N-2:0], qbit};
        r_d = pr_nxt[M-1:0];
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvsr_q <= '0;
      pr_q   <= '0;
      q_q    <= '0;
      r_q    <= '0;
`ifdef UDIV_ZERO_DETECT_EN
      dz_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvsr_q <= dvsr_d;
      pr_q   <= pr_d;
      q_q    <= q_d;
      r_q    <= r_d;
`ifdef UDIV_ZERO_DETECT_EN
      dz_q   <= dz_d;
`endif
    end
  end

  assign q = q_q;
  assign r = r_q;
`ifdef UDIV_ZERO_DETECT_EN
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_unsigned_divider.sv
// Directed and randomized checks for unsigned_divider (N=23, M=12).
module tb_unsigned_divider;

  localparam int N = 23;
  localparam int M = 12;

  logic         clk;
  logic         reset;
  logic [N-1:0] x;
  logic [M-1:0] y;
  logic         start;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [M-1:0] r;
  logic         div_zero;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int fails     = 0;

  unsigned_divider #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present operands, start sampled on the next rising edge (accept).
  task automatic drive_start(input logic [N-1:0] xv, input logic [M-1:0] yv);
    @(negedge clk);
    x     = xv;
    y     = yv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done after an accept; lat = edges after accept (0 on timeout).
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({busy, done, q, r, div_zero, dbg_state} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%0b done=%0b q=%0d r=%0d dz=%0b st=%0d, required all 0",
               busy, done, q, r, div_zero, dbg_state);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    drive_start(23'd1000, 12'd7);
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL basic_accept: busy=%0b done=%0b, required 1/0", busy, done);
    end
    wait_done(lat, bc);
    tests_run++;
    if (lat !== 23) begin
      fails++;
      $display("FAIL basic_latency: got %0d required 23", lat);
    end
    tests_run++;
    if (bc !== 23) begin
      fails++;
      $display("FAIL basic_busy_cycles: got %0d required 23", bc);
    end
    tests_run++;
    if (q !== 23'd142 || r !== 12'd6 || div_zero !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%0b, required 142 6 0", q, r, div_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    drive_start(23'd8388607, 12'd1);
    wait_done(lat, bc);
    tests_run++;
    if (lat !== 23 || q !== 23'd8388607 || r !== 12'd0) begin
      fails++;
      $display("FAIL max_by_one: lat=%0d q=%0d r=%0d, required 23 8388607 0", lat, q, r);
    end
    // Start accepted in DONE on the edge right after done rose.
    drive_start(23'd5, 12'd4095);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b1 || q !== 23'd8388607) begin
      fails++;
      $display("FAIL done_accept: done=%0b busy=%0b q=%0d, required 0 1 8388607", done, busy, q);
    end
    wait_done(lat, bc);
    tests_run++;
    if (lat !== 23 || q !== 23'd0 || r !== 12'd5) begin
      fails++;
      $display("FAIL small_by_max: lat=%0d q=%0d r=%0d, required 23 0 5", lat, q, r);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    drive_start(23'd1234, 12'd0);
    wait_done(lat, bc);
`ifdef UDIV_ZERO_DETECT_EN
    tests_run++;
    if (lat !== 1 || bc !== 0 || div_zero !== 1'b1) begin
      fails++;
      $display("FAIL div_zero_fast: lat=%0d busy_cycles=%0d dz=%0b, required 1 0 1", lat, bc, div_zero);
    end
`else
    tests_run++;
    if (lat !== 23 || bc !== 23 || div_zero !== 1'b0) begin
      fails++;
      $display("FAIL div_zero_slow: lat=%0d busy_cycles=%0d dz=%0b, required 23 23 0", lat, bc, div_zero);
    end
`endif
    tests_run++;
    if (q !== 23'd8388607 || r !== 12'd1234) begin
      fails++;
      $display("FAIL div_zero_result: q=%0d r=%0d, required 8388607 1234", q, r);
    end
  endtask

  task automatic test_start_ignored();
    int lat, bc;
    drive_start(23'd100, 12'd3);
    // 9 more edges -> re-pulse start during cycle 10 of CALC
    repeat (9) @(posedge clk);
    drive_start(23'd999, 12'd2);
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ignored_busy: busy=%0b required 1", busy);
    end
    wait_done(lat, bc);
    tests_run++;
    if (lat !== 13 || q !== 23'd33 || r !== 12'd1) begin
      fails++;
      $display("FAIL start_ignored: lat_after_repulse=%0d q=%0d r=%0d, required 13 33 1", lat, q, r);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    drive_start(23'd77777, 12'd100);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, q, r, div_zero, dbg_state} !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy=%0b done=%0b q=%0d r=%0d dz=%0b st=%0d, required all 0",
               busy, done, q, r, div_zero, dbg_state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: st=%0d busy=%0b, required 0 0", dbg_state, busy);
    end
    drive_start(23'd77777, 12'd100);
    wait_done(lat, bc);
    tests_run++;
    if (lat !== 23 || q !== 23'd777 || r !== 12'd77) begin
      fails++;
      $display("FAIL after_reset_op: lat=%0d q=%0d r=%0d, required 23 777 77", lat, q, r);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [N-1:0] xv;
    logic [M-1:0] yv;
    logic [N+M:0] recon;
    for (int i = 0; i < 2000; i++) begin
      xv = N'($urandom_range(0, (1 << N) - 1));
      yv = M'($urandom_range(1, (1 << M) - 1));
      drive_start(xv, yv);
      wait_done(lat, bc);
      recon = (N+M+1)'(q) * (N+M+1)'(yv) + (N+M+1)'(r);
      tests_run++;
      if (recon !== (N+M+1)'(xv) || r >= yv) begin
        fails++;
        $display("FAIL random_result: x=%0d y=%0d q=%0d r=%0d", xv, yv, q, r);
      end
      tests_run++;
      if (lat !== 23) begin
        fails++;
        $display("FAIL random_latency: got %0d required 23", lat);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
